// File: rtl/hh_bcd_reader.sv
// Reads the BCD hour byte from the RTC register bus, validates it (00-23), optionally
// converts it to 12 h with an AM/PM flag, and holds the result for the display path.
module hh_bcd_reader #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       formato_hora,
  input  logic       rd_ack,
  input  logic [7:0] data_bus_in,
  output logic       rd_req,
  output logic       busy,
  output logic [7:0] dato_HH,
  output logic       AM_PM,
  output logic       data_valid,
  output logic       error
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CHECK = 3'd2,
    CONV  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       raw_q, raw_d;
  logic [7:0]       dato_q, dato_d;
  logic             am_pm_q, am_pm_d;
  logic             error_q, error_d;
  logic             rd_req_q, rd_req_d;
  logic             busy_q, busy_d;
  logic             data_valid_q, data_valid_d;

  logic [3:0] tens, units;
  logic [4:0] units_m2;
  logic [3:0] units_n, tens_n;
  logic       borrow;
  logic       raw_ok;
  logic [7:0] conv_hh;
  logic       conv_pm;

  // BCD range check and 24 h -> 12 h conversion; h-12 is done digit-wise with a units borrow
  always_comb begin
    tens     = raw_q[7:4];
    units    = raw_q[3:0];
    raw_ok   = (tens <= 4'd2) && (units <= 4'd9) && (raw_q <= 8'h23);
    units_m2 = {1'b0, units} - 5'd2;
    borrow   = units_m2[4];
    units_n  = borrow ? (units + 4'd8) : units_m2[3:0];
    tens_n   = tens - 4'd1 - {3'b000, borrow};
    conv_hh  = raw_q;
    conv_pm  = 1'b0;
    if (formato_hora) begin
      if (raw_q == 8'h00) begin
        conv_hh = 8'h12;
      end else if (raw_q == 8'h12) begin
        conv_pm = 1'b1;
      end else if (raw_q > 8'h12) begin
        conv_hh = {tens_n, units_n};
        conv_pm = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    raw_d    = raw_q;
    dato_d   = dato_q;
    am_pm_d  = am_pm_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          error_d = 1'b0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        // An ack on the last allowed cycle takes priority over the timeout
        if (rd_ack) begin
          raw_d   = data_bus_in;
          state_d = CHECK;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (raw_ok) begin
          state_d = CONV;
        end else begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      CONV: begin
        dato_d  = conv_hh;
        am_pm_d = conv_pm;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_req_d     = (state_d == REQ);
    busy_d       = (state_d != IDLE);
    data_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      raw_q        <= '0;
      dato_q       <= '0;
      am_pm_q      <= 1'b0;
      error_q      <= 1'b0;
      rd_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      raw_q        <= raw_d;
      dato_q       <= dato_d;
      am_pm_q      <= am_pm_d;
      error_q      <= error_d;
      rd_req_q     <= rd_req_d;
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign rd_req     = rd_req_q;
  assign busy       = busy_q;
  assign dato_HH    = dato_q;
  assign AM_PM      = am_pm_q;
  assign data_valid = data_valid_q;
  assign error      = error_q;

endmodule

// File: tb/tb_hh_bcd_reader.sv
// Table-driven bench for hh_bcd_reader (TIMEOUT_CYC = 8): conversion sweep, invalid
// BCD, timeout boundary, busy/idle noise and asynchronous reset mid-request.
module tb_hh_bcd_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       formato_hora;
  logic       rd_ack;
  logic [7:0] data_bus_in;
  logic       rd_req, busy, AM_PM, data_valid, error;
  logic [7:0] dato_HH;

  int tests = 0;
  int fails = 0;

  hh_bcd_reader #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset), .start(start), .formato_hora(formato_hora),
    .rd_ack(rd_ack), .data_bus_in(data_bus_in), .rd_req(rd_req), .busy(busy),
    .dato_HH(dato_HH), .AM_PM(AM_PM), .data_valid(data_valid), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] din;
    logic       fmt;
    int         ack_at;     // REQ cycle carrying the ack, 0 = never
    bit         hold;       // keep ack high after the sampled edge
    bit         busy_start; // pulse start while busy
    logic [7:0] exp_dato;
    logic       exp_pm;
    logic       exp_err;
    int         exp_pulses;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int n, pulses, lat;
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    start = 1'b1;
    formato_hora = v.fmt;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rd_req && n < 40) begin
      n++;
      if (v.busy_start && n == 1) start = 1'b1;
      if (n == v.ack_at) begin
        rd_ack = 1'b1;
        data_bus_in = v.din;
      end
      @(negedge clk);
      start = 1'b0;
      if (!v.hold) rd_ack = 1'b0;
    end
    check($sformatf("v%0d req_cycles", i), n, (v.ack_at == 0) ? 8 : v.ack_at);
    if (v.ack_at == 0) check($sformatf("v%0d busy_after_timeout", i), int'(busy), 0);
    pulses = 0;
    lat = 0;
    for (int t = 1; t <= 6; t++) begin
      if (data_valid) begin
        pulses++;
        lat = t;
      end
      start = (v.busy_start && t == 1);
      @(negedge clk);
      start = 1'b0;
    end
    rd_ack = 1'b0;
    check($sformatf("v%0d valid_pulses", i), pulses, v.exp_pulses);
    if (v.exp_pulses == 1) check($sformatf("v%0d valid_latency", i), lat, 3);
    check($sformatf("v%0d dato_HH", i), int'(dato_HH), int'(v.exp_dato));
    check($sformatf("v%0d AM_PM", i), int'(AM_PM), int'(v.exp_pm));
    check($sformatf("v%0d error", i), int'(error), int'(v.exp_err));
    check($sformatf("v%0d busy_end", i), int'(busy), 0);
    check($sformatf("v%0d rd_req_end", i), int'(rd_req), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h17, 1'b0, 3, 1'b0, 1'b0, 8'h17, 1'b0, 1'b0, 1};
    vecs[1]  = '{8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1};
    vecs[2]  = '{8'h11, 1'b1, 2, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1};
    vecs[3]  = '{8'h12, 1'b1, 1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1};
    vecs[4]  = '{8'h13, 1'b1, 2, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1};
    vecs[5]  = '{8'h20, 1'b1, 1, 1'b0, 1'b0, 8'h08, 1'b1, 1'b0, 1};
    vecs[6]  = '{8'h23, 1'b1, 4, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1};
    vecs[7]  = '{8'h19, 1'b1, 1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1};
    vecs[8]  = '{8'h22, 1'b1, 2, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 1};
    vecs[9]  = '{8'h05, 1'b1, 1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1};
    vecs[10] = '{8'h1A, 1'b0, 1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 0};
    vecs[11] = '{8'h24, 1'b1, 2, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 0};
    vecs[12] = '{8'h30, 1'b0, 1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 0};
    vecs[13] = '{8'hFF, 1'b1, 3, 1'b0, 1'b0, 8'h05, 1'b0, 1'b1, 0};
    vecs[14] = '{8'h09, 1'b0, 8, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0, 1};
    vecs[15] = '{8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h09, 1'b0, 1'b1, 0};
    vecs[16] = '{8'h15, 1'b1, 4, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1};
    vecs[17] = '{8'h21, 1'b0, 2, 1'b1, 1'b0, 8'h21, 1'b0, 1'b0, 1};

    reset = 1'b1;
    start = 1'b0;
    formato_hora = 1'b0;
    rd_ack = 1'b0;
    data_bus_in = 8'h00;
    repeat (2) @(negedge clk);
    check("reset dato_HH", int'(dato_HH), 0);
    check("reset flags", int'({rd_req, busy, AM_PM, data_valid, error}), 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Acks while idle must be ignored
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rd_ack = 1'b1;
      data_bus_in = 8'h07;
    end
    @(negedge clk);
    rd_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("idle_ack flags", int'({rd_req, busy, data_valid}), 0);
      check("idle_ack dato_HH", int'(dato_HH), 'h21);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a request
    start = 1'b1;
    formato_hora = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset rd_req", int'(rd_req), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_reset rd_req", int'(rd_req), 0);
    check("mid_reset busy", int'(busy), 0);
    check("mid_reset dato_HH", int'(dato_HH), 0);
    check("mid_reset others", int'({AM_PM, data_valid, error}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
